exc_int_ctrl: RTL
=================

Name: exc_int_ctrl

Overview:
- Requester side of the CP0 exception/interrupt interface.
- Synchronises and latches device interrupt lines, then masks them with CP0 status bits (SR_IM, SR_ie, SR_exl).
- Arbitrates pending interrupts against synchronous exceptions from decode.
- Drives the one-cycle ExcEnter pulse with ExcCode and a snapshot of HWInt into CP0.
- Tracks handler residency until eret so the multi-cycle control FSM can redirect fetch.

Parameters:
- N_IRQ, 5, number of device interrupt lines; maps to HWInt[6:2] / IM[6:2].
- SYNC_STAGES, 2, synchroniser depth per IRQ line (minimum 2).
- EDGE_MASK, 5'b00000, per-line mode: 1 = rising-edge latched, 0 = level.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- IrqIn  in  N_IRQ  raw device interrupt lines, asynchronous to Clk
- IrqClr  in  N_IRQ  one-cycle clear pulses for edge-latched pending bits (device register write)
- SR_IM  in  6  CP0 interrupt mask [7:2]; only bits [6:2] are used
- SR_ie  in  1  CP0 global interrupt enable
- SR_exl  in  1  CP0 exception level
- InstrBoundary  in  1  control FSM is in fetch state; an interrupt may be taken this cycle
- SyscallReq  in  1  one-cycle pulse from decode
- BreakReq  in  1  one-cycle pulse from decode
- RIReq  in  1  one-cycle pulse, reserved instruction
- Eret  in  1  one-cycle pulse, eret executing
- ExcEnter  out  1  one-cycle pulse to CP0 and control FSM
- ExcCode  out  5  cause code [6:2], valid while ExcEnter is high
- HWInt  out  N_IRQ  pending snapshot [6:2], valid while ExcEnter is high
- IntPending  out  1  enabled interrupt waiting for a boundary
- InHandler  out  1  between ExcEnter and Eret
- IntLatMax  out  16  worst-case interrupt latency (optional feature)

Behaviour:
- Reset (async assert, sync deassert through the internal flop chain) clears everything. ExcEnter=0, ExcCode=0, HWInt=0, IntPending=0, InHandler=0, IntLatMax=0. Synchroniser chains and pending register = 0. State = IDLE.
- Synchroniser: IrqIn[i] passes through SYNC_STAGES flops giving irq_s[i]. Latency from IrqIn to pending is SYNC_STAGES+1 cycles for edge lines and SYNC_STAGES cycles for level lines.
- Level line: pend[i] = irq_s[i], combinational from the last sync stage. It is not latched and IrqClr has no effect.
- Edge line: pend[i] is set on irq_s[i] & ~irq_s_d[i] and cleared by IrqClr[i]. If set and clear occur in the same cycle, set wins.
- Interrupt eligible: en = pend & SR_IM[6:2]; eligible = |en & SR_ie & ~SR_exl & (state==IDLE). IntPending = eligible (registered, 1-cycle lag).
- Sync exception priority when several are requested in the same cycle: RIReq (10) > BreakReq (9) > SyscallReq (8).
- Any sync exception beats a simultaneous interrupt. The interrupt stays pending and is not lost.
- States:
  - IDLE: on any sync req, go to ENTER with code from the priority list and HWInt = pend. Else if eligible & InstrBoundary, go to ENTER with code 0 and HWInt = pend.
  - ENTER: ExcEnter=1 for exactly one cycle with ExcCode/HWInt held. Next state is HANDLER.
  - HANDLER: InHandler=1 and interrupts are blocked regardless of SR bits. A sync req here goes to ENTER again (nested sync exception). Eret goes to IDLE. If Eret and a sync req arrive in the same cycle, the sync req wins and Eret is ignored.
- ExcCode/HWInt are registered alongside the ENTER transition and hold their value until the next ENTER.
- Sync req pulses arriving while in ENTER are dropped; decode cannot issue them in that cycle.
- Eret in IDLE or ENTER is ignored.
- Reset_n asserted mid-handler aborts the handler: InHandler=0 immediately and all pending edges are discarded.

Optional Feature:
- Macro: EXC_INT_LATENCY_EN.
- When defined: a 16-bit counter runs while eligible=1 and state==IDLE, and clears on entering ENTER.
- IntLatMax captures max(IntLatMax, count) on each interrupt ENTER and saturates at 16'hFFFF.
- When the macro is undefined: no counter is instantiated and IntLatMax is tied to 16'h0000.

Test Plan:
- Level IRQ1 high with SR_IM=6'h3F, ie=1, exl=0, InstrBoundary held 1 -> ExcEnter pulses exactly 3 cycles after IrqIn rises (SYNC_STAGES=2), with ExcCode=0, HWInt=5'b00010, then InHandler=1.
- SyscallReq and BreakReq in the same cycle as an eligible IRQ0 -> single ExcEnter with ExcCode=9. After Eret with InstrBoundary=1 -> second ExcEnter with ExcCode=0, HWInt[0]=1.
- IRQ2 pending with SR_IM[4]=0, or with SR_exl=1 -> no ExcEnter and IntPending=0. Setting the mask bit -> ExcEnter at the next InstrBoundary.
- EDGE_MASK=5'b00001: a 1-cycle glitch on IrqIn[0] latches pend[0]. IrqClr[0] asserted on the same cycle as a new edge leaves pend[0]=1. IrqClr[0] alone -> pend[0]=0.
- RIReq while in HANDLER -> ExcEnter with ExcCode=10 and InHandler stays 1. Reset_n pulse low mid-handler -> all outputs 0 asynchronously.
- With EXC_INT_LATENCY_EN defined, InstrBoundary withheld 7 cycles after eligibility -> IntLatMax=7. A subsequent 3-cycle wait -> IntLatMax stays 7.

Source files
------------

// File: rtl/exc_int_ctrl.sv
// ----------------------------------------------------------------------------
// exc_int_ctrl
//
// Requester side of the CP0 exception/interrupt interface. Device interrupt
// lines are synchronised and either passed through (level lines) or latched
// on a rising edge (edge lines). They are then masked with the CP0 status
// bits and arbitrated against synchronous exceptions from decode. The block
// issues a one-cycle ExcEnter pulse carrying the cause code and a snapshot
// of the pending lines, and tracks handler residency until eret.
//
// Parameters
//   N_IRQ        number of device interrupt lines (HWInt[6:2] / IM[6:2])
//   SYNC_STAGES  synchroniser depth per line, minimum 2
//   EDGE_MASK    per-line mode: 1 = rising-edge latched, 0 = level
//
// Ports
//   Clk, Reset_n   clock, asynchronous active-low reset
//   IrqIn          raw device interrupt lines (asynchronous to Clk)
//   IrqClr         one-cycle clear pulses for edge-latched pending bits
//   SR_IM          CP0 interrupt mask [7:2]; bits [6:2] are used
//   SR_ie, SR_exl  CP0 global enable and exception level
//   InstrBoundary  control FSM is in fetch; an interrupt may be taken
//   SyscallReq, BreakReq, RIReq  one-cycle sync exception requests
//   Eret           one-cycle pulse, eret executing
//   ExcEnter       one-cycle entry pulse to CP0 and the control FSM
//   ExcCode        cause code [6:2], valid while ExcEnter is high
//   HWInt          pending snapshot [6:2], valid while ExcEnter is high
//   IntPending     enabled interrupt waiting for a boundary (1-cycle lag)
//   InHandler      high between ExcEnter and Eret
//   IntLatMax      worst-case interrupt latency in cycles
//
// Optional feature
//   Define EXC_INT_LATENCY_EN to build the latency counter behind IntLatMax.
//   Without it IntLatMax is tied to zero.
// ----------------------------------------------------------------------------
module exc_int_ctrl #(
    parameter int               N_IRQ       = 5,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_IRQ-1:0] IrqIn,
    input  logic [N_IRQ-1:0] IrqClr,
    input  logic [5:0]       SR_IM,
    input  logic             SR_ie,
    input  logic             SR_exl,
    input  logic             InstrBoundary,
    input  logic             SyscallReq,
    input  logic             BreakReq,
    input  logic             RIReq,
    input  logic             Eret,
    output logic             ExcEnter,
    output logic [4:0]       ExcCode,
    output logic [N_IRQ-1:0] HWInt,
    output logic             IntPending,
    output logic             InHandler,
    output logic [15:0]      IntLatMax
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2
    } state_e;

    localparam logic [4:0] CODE_INT = 5'd0;
    localparam logic [4:0] CODE_SYS = 5'd8;
    localparam logic [4:0] CODE_BP  = 5'd9;
    localparam logic [4:0] CODE_RI  = 5'd10;

    // ------------------------------------------------------------------
    // Synchroniser and pending logic
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
    logic [N_IRQ-1:0]                  irq_s;
    logic [N_IRQ-1:0]                  irq_s_d_q;
    logic [N_IRQ-1:0]                  edge_pend_q, edge_pend_d;
    logic [N_IRQ-1:0]                  pend;

    assign irq_s = sync_q[SYNC_STAGES-1];

    // NOTE: the synchroniser stages are reset along with everything else so
    // a stale high sample cannot fake an edge right after reset release.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the clock edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q      <= '0;
            irq_s_d_q   <= '0;
            edge_pend_q <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], IrqIn};
            irq_s_d_q   <= irq_s;
            edge_pend_q <= edge_pend_d;
        end
    end

    // Set term is OR-ed after the clear so a coincident new edge wins.
    assign edge_pend_d = ((edge_pend_q & ~IrqClr) | (irq_s & ~irq_s_d_q)) & EDGE_MASK;

    // Level lines come straight from the last sync stage; edge lines from the latch.
    assign pend = (irq_s & ~EDGE_MASK) | (edge_pend_q & EDGE_MASK);

    // SR_IM[5] maps to IM7, which has no device line.
    logic unused_sr_im7;
    assign unused_sr_im7 = SR_IM[5];

    // ------------------------------------------------------------------
    // Eligibility and arbitration
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic [N_IRQ-1:0] hwint_q, hwint_d;
    logic             in_handler_q, in_handler_d;
    logic             int_pend_q;
    logic             eligible;
    logic             sync_req;
    logic [4:0]       sync_code;
    logic             take_int;
    logic             entering;

    assign eligible = (|(pend & SR_IM[N_IRQ-1:0])) & SR_ie & ~SR_exl
                      & (state_q == ST_IDLE);

    assign sync_req  = RIReq | BreakReq | SyscallReq;
    assign sync_code = RIReq    ? CODE_RI :
                       BreakReq ? CODE_BP : CODE_SYS;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        exc_code_d   = exc_code_q;
        hwint_d      = hwint_q;
        in_handler_d = in_handler_q;
        take_int     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync_req) begin
                    state_d    = ST_ENTER;
                    exc_code_d = sync_code;
                    hwint_d    = pend;
                end else if (eligible && InstrBoundary) begin
                    state_d    = ST_ENTER;
                    exc_code_d = CODE_INT;
                    hwint_d    = pend;
                    take_int   = 1'b1;
                end
            end
            ST_ENTER: begin
                // Requests in this cycle are dropped; decode cannot issue them.
                state_d      = ST_HANDLER;
                in_handler_d = 1'b1;
            end
            ST_HANDLER: begin
                // A nested sync exception takes priority over a coincident eret.
                if (sync_req) begin
                    state_d    = ST_ENTER;
                    exc_code_d = sync_code;
                    hwint_d    = pend;
                end else if (Eret) begin
                    state_d      = ST_IDLE;
                    in_handler_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                in_handler_d = 1'b0;
            end
        endcase
    end

    assign entering = (state_d == ST_ENTER);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            exc_code_q   <= '0;
            hwint_q      <= '0;
            in_handler_q <= 1'b0;
            int_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            exc_code_q   <= exc_code_d;
            hwint_q      <= hwint_d;
            in_handler_q <= in_handler_d;
            int_pend_q   <= eligible;
        end
    end

    assign ExcEnter   = (state_q == ST_ENTER);
    assign ExcCode    = exc_code_q;
    assign HWInt      = hwint_q;
    assign IntPending = int_pend_q;
    // Stays high through a nested ENTER because the flag is only cleared by eret.
    assign InHandler  = in_handler_q;

    // ------------------------------------------------------------------
    // Optional worst-case interrupt latency tracking
    // ------------------------------------------------------------------
`ifdef EXC_INT_LATENCY_EN
    logic [15:0] lat_cnt_q, lat_cnt_d;
    logic [15:0] lat_max_q, lat_max_d;

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        lat_max_d = lat_max_q;
        if (entering) begin
            lat_cnt_d = '0;
        end else if (eligible && (lat_cnt_q != 16'hFFFF)) begin
            lat_cnt_d = lat_cnt_q + 16'd1;
        end
        // Counter saturates, so the captured maximum saturates with it.
        if (take_int && (lat_cnt_q > lat_max_q)) begin
            lat_max_d = lat_cnt_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lat_cnt_q <= '0;
            lat_max_q <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            lat_max_q <= lat_max_d;
        end
    end

    assign IntLatMax = lat_max_q;
`else
    logic unused_take_int;
    logic unused_entering;
    assign unused_take_int = take_int;
    assign unused_entering = entering;
    assign IntLatMax       = 16'h0000;
`endif

endmodule
